// File: rtl/spw_rx_char_decoder_pkg.sv
// Shared codes, state encoding and parity helper for the SpaceWire RX character decoder.
package spw_rx_pkg;

   // Control character payload codes (payload bits as {c[1], c[0]}, c[0] arrives first)
   localparam logic [1:0] C_FCT = 2'b00;
   localparam logic [1:0] C_EOP = 2'b01;
   localparam logic [1:0] C_EEP = 2'b10;
   localparam logic [1:0] C_ESC = 2'b11;

   // NULL (ESC+FCT) without its leading parity bit, oldest bit in the MSB
   localparam logic [6:0] NULL_TAIL = 7'b1110100;

   typedef enum logic [1:0] {
      HUNT = 2'd0,
      HEAD = 2'd1,
      CTRL = 2'd2,
      DATA = 2'd3
   } rx_state_t;

   // Odd parity over previous payload, this parity bit and this flag
   function automatic logic parity_ok(input logic p, input logic flag, input logic prev_par);
      return ((p ^ flag ^ prev_par) == 1'b1);
   endfunction

endpackage

// File: rtl/spw_rx_char_decoder_if.sv
// Bit-pair input and decoded-character outputs of the SpaceWire RX character decoder.
interface spw_rx_char_decoder_if;
   logic       rx_pair_valid;
   logic [1:0] rx_bit_pair;
   logic       rx_synced;
   logic       rx_got_bit;
   logic       rx_got_null;
   logic       rx_got_fct;
   logic       rx_data_valid;
   logic [8:0] rx_data;
   logic       rx_tick;
   logic [7:0] rx_time;
   logic       rx_parity_error;
   logic       rx_esc_error;

   // Decoder side
   modport slave (
      input  rx_pair_valid, rx_bit_pair,
      output rx_synced, rx_got_bit, rx_got_null, rx_got_fct, rx_data_valid, rx_data,
             rx_tick, rx_time, rx_parity_error, rx_esc_error
   );

   // Bit-capture / consumer side
   modport master (
      output rx_pair_valid, rx_bit_pair,
      input  rx_synced, rx_got_bit, rx_got_null, rx_got_fct, rx_data_valid, rx_data,
             rx_tick, rx_time, rx_parity_error, rx_esc_error
   );
endinterface

// File: rtl/spw_rx_char_decoder_bit_aligner.sv
// Hunts for the first NULL tail at either bit offset and then re-pairs the incoming
// bits so that every effective pair starts on a character bit boundary.
module spw_rx_bit_aligner
   import spw_rx_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_pair_valid,
   input  logic [1:0] i_bit_pair,
   input  logic       i_hunt_req,
   output logic [1:0] o_eff_pair,
   output logic       o_eff_valid,
   output logic       o_null_found
);

   // Only the six newest history bits ever reach a 7-bit match window once the
   // current pair is appended, so older history is not stored.
   logic [5:0] r_hist;
   logic       r_phase;
   logic       r_carry;
   logic       r_locked;

   logic [7:0] w_hist_next;
   logic       w_off0;
   logic       w_off1;

   assign w_hist_next = {r_hist, i_bit_pair};
   assign w_off0      = (w_hist_next[6:0] == NULL_TAIL);
   assign w_off1      = (w_hist_next[7:1] == NULL_TAIL);

   // Effective pair selection and strobes for the framer
   always_comb begin
      o_eff_pair   = i_bit_pair;
      o_eff_valid  = 1'b0;
      o_null_found = 1'b0;
      if (r_phase) begin
         o_eff_pair = {r_carry, i_bit_pair[1]};
      end else begin
         o_eff_pair = i_bit_pair;
      end
      if (r_locked) begin
         o_eff_valid = i_pair_valid;
      end else begin
         o_null_found = i_pair_valid & (w_off0 | w_off1);
      end
   end

   // History shift while hunting, phase/carry lock on the NULL tail, re-arm on request
   always_ff @(posedge i_clk) begin
      if (i_rst || i_hunt_req) begin
         r_hist   <= 6'd0;
         r_phase  <= 1'b0;
         r_carry  <= 1'b0;
         r_locked <= 1'b0;
      end else if (i_pair_valid) begin
         if (!r_locked) begin
            r_hist <= w_hist_next[5:0];
            if (w_off0) begin
               r_locked <= 1'b1;
               r_phase  <= 1'b0;
            end else if (w_off1) begin
               r_locked <= 1'b1;
               r_phase  <= 1'b1;
               r_carry  <= i_bit_pair[0];
            end
         end else if (r_phase) begin
            r_carry <= i_bit_pair[0];
         end
      end
   end

endmodule

// File: rtl/spw_rx_char_decoder.sv
// SpaceWire receive character decoder: frames control/data characters after NULL
// alignment, checks odd parity and decodes FCT, NULL, EOP, EEP, data and time-codes.
module spw_rx_char_decoder
   import spw_rx_pkg::*;
(
   input logic                  posedge_clk,
   input logic                  rx_reset,
   spw_rx_char_decoder_if.slave bus
);

   rx_state_t  r_state;
   logic [1:0] r_cnt;
   logic [7:0] r_byte;
   logic       r_esc_pend;
   logic       r_prev_par;

   logic       r_synced;
   logic       r_got_bit;
   logic       r_got_null;
   logic       r_got_fct;
   logic       r_data_valid;
   logic [8:0] r_data;
   logic       r_tick;
   logic [7:0] r_time;
   logic       r_parity_error;
   logic       r_esc_error;

   logic [1:0] w_eff_pair;
   logic       w_eff_valid;
   logic       w_null_found;
   logic       w_hunt_req;
   logic       w_par_ok;
   logic [1:0] w_ctrl_code;
   logic [7:0] w_byte_next;

   spw_rx_bit_aligner u_aligner (
      .i_clk        (posedge_clk),
      .i_rst        (rx_reset),
      .i_pair_valid (bus.rx_pair_valid),
      .i_bit_pair   (bus.rx_bit_pair),
      .i_hunt_req   (w_hunt_req),
      .o_eff_pair   (w_eff_pair),
      .o_eff_valid  (w_eff_valid),
      .o_null_found (w_null_found)
   );

   // First-arriving payload bit is the LSB
   assign w_ctrl_code = {w_eff_pair[0], w_eff_pair[1]};
   assign w_byte_next = {w_eff_pair[0], w_eff_pair[1], r_byte[7:2]};
   assign w_par_ok    = parity_ok(w_eff_pair[1], w_eff_pair[0], r_prev_par);

   // Framing loss that sends the aligner back to hunting for a NULL
   always_comb begin
      w_hunt_req = 1'b0;
      if (!w_eff_valid) begin
         w_hunt_req = 1'b0;
      end else if (r_state == HEAD) begin
         w_hunt_req = ~w_par_ok;
      end else if (r_state == CTRL) begin
         w_hunt_req = r_esc_pend & (w_ctrl_code != C_FCT);
      end else begin
         w_hunt_req = 1'b0;
      end
   end

   // Framer FSM with registered decode pulses
   always_ff @(posedge posedge_clk) begin
      if (rx_reset) begin
         r_state        <= HUNT;
         r_cnt          <= 2'd0;
         r_byte         <= 8'd0;
         r_esc_pend     <= 1'b0;
         r_prev_par     <= 1'b0;
         r_synced       <= 1'b0;
         r_got_bit      <= 1'b0;
         r_got_null     <= 1'b0;
         r_got_fct      <= 1'b0;
         r_data_valid   <= 1'b0;
         r_data         <= 9'd0;
         r_tick         <= 1'b0;
         r_time         <= 8'd0;
         r_parity_error <= 1'b0;
         r_esc_error    <= 1'b0;
      end else begin
         r_got_bit      <= bus.rx_pair_valid;
         r_got_null     <= 1'b0;
         r_got_fct      <= 1'b0;
         r_data_valid   <= 1'b0;
         r_tick         <= 1'b0;
         r_parity_error <= 1'b0;
         r_esc_error    <= 1'b0;
         case (r_state)
            HUNT: begin
               if (w_null_found) begin
                  r_got_null <= 1'b1;
                  r_synced   <= 1'b1;
                  r_prev_par <= 1'b0;
                  r_esc_pend <= 1'b0;
                  r_state    <= HEAD;
               end
            end
            HEAD: begin
               if (w_eff_valid) begin
                  if (!w_par_ok) begin
                     r_parity_error <= 1'b1;
                     r_synced       <= 1'b0;
                     r_esc_pend     <= 1'b0;
                     r_state        <= HUNT;
                  end else if (w_eff_pair[0]) begin
                     r_state <= CTRL;
                  end else begin
                     r_cnt   <= 2'd0;
                     r_state <= DATA;
                  end
               end
            end
            CTRL: begin
               if (w_eff_valid) begin
                  r_prev_par <= ^w_ctrl_code;
                  r_state    <= HEAD;
                  if (r_esc_pend && (w_ctrl_code != C_FCT)) begin
                     r_esc_error <= 1'b1;
                     r_synced    <= 1'b0;
                     r_esc_pend  <= 1'b0;
                     r_state     <= HUNT;
                  end else begin
                     case (w_ctrl_code)
                        C_ESC: r_esc_pend <= 1'b1;
                        C_FCT: begin
                           r_got_null <= r_esc_pend;
                           r_got_fct  <= ~r_esc_pend;
                           r_esc_pend <= 1'b0;
                        end
                        C_EOP: begin
                           r_data_valid <= 1'b1;
                           r_data       <= {1'b1, 8'h00};
                        end
                        C_EEP: begin
                           r_data_valid <= 1'b1;
                           r_data       <= {1'b1, 8'h01};
                        end
                        default: r_esc_pend <= 1'b0;
                     endcase
                  end
               end
            end
            DATA: begin
               if (w_eff_valid) begin
                  r_byte <= w_byte_next;
                  if (r_cnt == 2'd3) begin
                     r_prev_par <= ^w_byte_next;
                     r_state    <= HEAD;
                     if (r_esc_pend) begin
                        r_tick     <= 1'b1;
                        r_time     <= w_byte_next;
                        r_esc_pend <= 1'b0;
                     end else begin
                        r_data_valid <= 1'b1;
                        r_data       <= {1'b0, w_byte_next};
                     end
                  end else begin
                     r_cnt <= r_cnt + 2'd1;
                  end
               end
            end
            default: r_state <= HUNT;
         endcase
      end
   end

   assign bus.rx_synced       = r_synced;
   assign bus.rx_got_bit      = r_got_bit;
   assign bus.rx_got_null     = r_got_null;
   assign bus.rx_got_fct      = r_got_fct;
   assign bus.rx_data_valid   = r_data_valid;
   assign bus.rx_data         = r_data;
   assign bus.rx_tick         = r_tick;
   assign bus.rx_time         = r_time;
   assign bus.rx_parity_error = r_parity_error;
   assign bus.rx_esc_error    = r_esc_error;

endmodule

// File: tb/tb_spw_rx_char_decoder.sv
// Directed bench for the SpaceWire RX character decoder: bit-level stimulus with a
// parity model for generating characters, hand-computed expected decode results.
module tb_spw_rx_char_decoder;
   import spw_rx_pkg::*;

   logic posedge_clk = 1'b0;
   logic rx_reset    = 1'b1;

   spw_rx_char_decoder_if ifc ();

   spw_rx_char_decoder dut (
      .posedge_clk (posedge_clk),
      .rx_reset    (rx_reset),
      .bus         (ifc)
   );

   always #5 posedge_clk = ~posedge_clk;

   int   total = 0;
   int   bad   = 0;
   int   n_null, n_fct, n_dv, n_tick, n_perr, n_eerr, n_bit;
   logic have_bit = 1'b0;
   logic first_bit = 1'b0;
   logic tb_par = 1'b0;

   task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_counts();
      n_null = 0; n_fct = 0; n_dv = 0; n_tick = 0; n_perr = 0; n_eerr = 0; n_bit = 0;
   endtask

   task automatic sample();
      n_null += int'(ifc.rx_got_null);
      n_fct  += int'(ifc.rx_got_fct);
      n_dv   += int'(ifc.rx_data_valid);
      n_tick += int'(ifc.rx_tick);
      n_perr += int'(ifc.rx_parity_error);
      n_eerr += int'(ifc.rx_esc_error);
      n_bit  += int'(ifc.rx_got_bit);
   endtask

   task automatic send_pair(input logic [1:0] pr);
      ifc.rx_pair_valid = 1'b1;
      ifc.rx_bit_pair   = pr;
      @(posedge posedge_clk);
      #1;
      ifc.rx_pair_valid = 1'b0;
      sample();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         ifc.rx_pair_valid = 1'b0;
         ifc.rx_bit_pair   = 2'b11;
         @(posedge posedge_clk);
         #1;
         sample();
      end
   endtask

   task automatic push_bit(input logic b);
      if (!have_bit) begin
         first_bit = b;
         have_bit  = 1'b1;
      end else begin
         have_bit = 1'b0;
         send_pair({first_bit, b});
      end
   endtask

   task automatic send_ctrl(input logic [1:0] c);
      push_bit(tb_par);
      push_bit(1'b1);
      push_bit(c[0]);
      push_bit(c[1]);
      tb_par = c[0] ^ c[1];
   endtask

   task automatic send_data(input logic [7:0] d);
      push_bit(~tb_par);
      push_bit(1'b0);
      for (int i = 0; i < 8; i++) push_bit(d[i]);
      tb_par = ^d;
   endtask

   task automatic send_null();
      send_ctrl(C_ESC);
      send_ctrl(C_FCT);
   endtask

   task automatic do_reset();
      rx_reset          = 1'b1;
      ifc.rx_pair_valid = 1'b0;
      ifc.rx_bit_pair   = 2'b00;
      repeat (2) @(posedge posedge_clk);
      #1;
      rx_reset = 1'b0;
      have_bit = 1'b0;
      tb_par   = 1'b0;
   endtask

   initial begin
      ifc.rx_pair_valid = 1'b0;
      ifc.rx_bit_pair   = 2'b00;
      clear_counts();

      // Reset state
      do_reset();
      check("rst_synced", 9'(ifc.rx_synced), 9'd0);
      check("rst_got_bit", 9'(ifc.rx_got_bit), 9'd0);
      check("rst_data", ifc.rx_data, 9'd0);
      check("rst_time", 9'(ifc.rx_time), 9'd0);
      check("rst_perr", 9'(ifc.rx_parity_error), 9'd0);

      // Clean NULLs at phase 0
      send_null();
      check("null1_synced", 9'(ifc.rx_synced), 9'd1);
      check("null1_pulse", 9'(ifc.rx_got_null), 9'd1);
      clear_counts();
      send_null();
      idle(3);
      send_null();
      check("nulls_count", 9'(n_null), 9'd2);
      check("nulls_bits", 9'(n_bit), 9'd8);
      check("nulls_errs", 9'(n_perr + n_eerr), 9'd0);
      check("nulls_synced", 9'(ifc.rx_synced), 9'd1);

      // Data byte and EOP
      send_data(8'hA5);
      check("a5_valid", 9'(ifc.rx_data_valid), 9'd1);
      check("a5_data", ifc.rx_data, 9'h0A5);
      check("a5_perr", 9'(ifc.rx_parity_error), 9'd0);
      send_ctrl(C_EOP);
      check("eop_valid", 9'(ifc.rx_data_valid), 9'd1);
      check("eop_data", ifc.rx_data, 9'h100);

      // Time-code then plain FCT
      send_ctrl(C_ESC);
      check("esc_quiet", 9'({ifc.rx_data_valid, ifc.rx_got_fct, ifc.rx_got_null}), 9'd0);
      clear_counts();
      send_data(8'h3F);
      check("tc_tick", 9'(ifc.rx_tick), 9'd1);
      check("tc_time", 9'(ifc.rx_time), 9'h03F);
      check("tc_no_dv", 9'(n_dv), 9'd0);
      send_ctrl(C_FCT);
      check("fct_pulse", 9'(ifc.rx_got_fct), 9'd1);
      check("fct_not_null", 9'(ifc.rx_got_null), 9'd0);

      // ESC followed by EEP
      send_ctrl(C_ESC);
      send_ctrl(C_EEP);
      check("eerr_pulse", 9'(ifc.rx_esc_error), 9'd1);
      check("eerr_synced", 9'(ifc.rx_synced), 9'd0);
      check("eerr_no_dv", 9'(ifc.rx_data_valid), 9'd0);
      tb_par = 1'b0;
      send_null();
      check("resync1_synced", 9'(ifc.rx_synced), 9'd1);
      check("resync1_null", 9'(ifc.rx_got_null), 9'd1);

      // Flipped parity on a data character (correct P would be 1)
      push_bit(1'b0);
      push_bit(1'b0);
      check("perr_pulse", 9'(ifc.rx_parity_error), 9'd1);
      check("perr_synced", 9'(ifc.rx_synced), 9'd0);
      clear_counts();
      for (int i = 0; i < 8; i++) push_bit(1'b0);
      check("perr_no_dv", 9'(n_dv), 9'd0);
      check("perr_still_hunt", 9'(ifc.rx_synced), 9'd0);

      // Reset in the middle of a data character
      tb_par = 1'b0;
      send_null();
      check("resync2_synced", 9'(ifc.rx_synced), 9'd1);
      push_bit(1'b1);
      push_bit(1'b0);
      for (int i = 0; i < 4; i++) push_bit(1'b0);
      rx_reset          = 1'b1;
      ifc.rx_pair_valid = 1'b1;
      ifc.rx_bit_pair   = 2'b00;
      @(posedge posedge_clk);
      #1;
      check("midrst_synced", 9'(ifc.rx_synced), 9'd0);
      check("midrst_got_bit", 9'(ifc.rx_got_bit), 9'd0);
      check("midrst_data", ifc.rx_data, 9'd0);
      check("midrst_time", 9'(ifc.rx_time), 9'd0);
      check("midrst_dv", 9'(ifc.rx_data_valid), 9'd0);
      rx_reset          = 1'b0;
      ifc.rx_pair_valid = 1'b0;
      have_bit          = 1'b0;
      clear_counts();
      push_bit(1'b0);
      push_bit(1'b0);
      check("midrst_partial_dv", 9'(n_dv), 9'd0);
      tb_par = 1'b0;
      send_null();
      check("resync3_synced", 9'(ifc.rx_synced), 9'd1);
      check("resync3_null", 9'(ifc.rx_got_null), 9'd1);

      // NULL stream shifted by one bit: phase 1 alignment
      do_reset();
      clear_counts();
      push_bit(1'b0);
      send_null();
      send_null();
      send_null();
      send_data(8'hA5);
      push_bit(1'b0);
      check("ph1_nulls", 9'(n_null), 9'd3);
      check("ph1_dv", 9'(n_dv), 9'd1);
      check("ph1_data", ifc.rx_data, 9'h0A5);
      check("ph1_synced", 9'(ifc.rx_synced), 9'd1);
      check("ph1_errs", 9'(n_perr + n_eerr), 9'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
